sequence_timing_unit: RTL



---
 rtl/sequence_timing_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/sequence_timing_unit.sv
// Sequence counter (SC), start/stop flip-flop (S) and one-hot timing decoder
// for the basic computer. SC+1 and its carry come from a single ripple-carry
// incrementer; this block registers them and decodes SC into T0..T(2**BITS-1).

// BITS-wide ripple-carry incrementer: data_out = data_in + 1, c_out = carry out.
module ripple_carry_incrementer #(
    parameter int unsigned BITS = 4
) (
    input  logic [BITS-1:0] data_in,
    output logic [BITS-1:0] data_out,
    output logic            c_out
);

    logic [BITS:0] carry;

    // Half-adder chain with a constant carry-in of one.
    always_comb begin
        carry    = '0;
        data_out = '0;
        carry[0] = 1'b1;
        for (int unsigned i = 0; i < BITS; i++) begin
            data_out[i]  = data_in[i] ^ carry[i];
            carry[i+1]   = data_in[i] & carry[i];
        end
        c_out = carry[BITS];
    end

endmodule

module sequence_timing_unit #(
    parameter int unsigned BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 clr,
    output logic                 running,
    output logic [BITS-1:0]      sc_out,
    output logic [2**BITS-1:0]   t_out,
    output logic                 wrap_out
);

    logic [BITS-1:0] sc_next;
    logic            sc_carry;

    ripple_carry_incrementer #(
        .BITS (BITS)
    ) u_inc (
        .data_in  (sc_out),
        .data_out (sc_next),
        .c_out    (sc_carry)
    );

    // S flip-flop, SC and wrap pulse; priority reset > halt > clr > increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            running  <= 1'b0;
            sc_out   <= '0;
            wrap_out <= 1'b0;
        end else if (halt) begin
            running  <= 1'b0;
            sc_out   <= '0;
            wrap_out <= 1'b0;
        end else begin
            // Start only arms S; SC stays put on that edge because the
            // increment below is gated by the old value of running.
            if (start && !running) begin
                running <= 1'b1;
            end
            if (clr) begin
                sc_out   <= '0;
                wrap_out <= 1'b0;
            end else if (running) begin
                sc_out   <= sc_next;
                wrap_out <= sc_carry;
            end else begin
                wrap_out <= 1'b0;
            end
        end
    end

    // Timing decoder: one-hot Tk for SC=k while running, all zeros when stopped.
    always_comb begin
        t_out = '0;
        if (running) begin
            t_out[sc_out] = 1'b1;
        end
    end

endmodule
